// File: rtl/ps2_pkg.sv
// Shared types and frame constants for the PS/2 receive path.
package ps2_pkg;

    localparam int PS2_DATA_BITS  = 8;
    localparam int PS2_FRAME_BITS = 11;  // start + 8 data + parity + stop

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

endpackage

// File: rtl/ps2_rx_fifo_if.sv
// Read-side handshake bundle: the receiver drives bytes out, the consumer accepts them.
interface ps2_rx_fifo_if #(
    parameter int FIFO_DEPTH = 8
) ();
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [7:0]       rd_data;
    logic             rd_valid;
    logic             rd_ready;
    logic [CNT_W-1:0] fifo_count;

    modport master (
        output rd_data,
        output rd_valid,
        output fifo_count,
        input  rd_ready
    );

    modport slave (
        input  rd_data,
        input  rd_valid,
        input  fifo_count,
        output rd_ready
    );
endinterface

// File: rtl/ps2_sync_fifo.sv
// First-word-fall-through byte FIFO. A push to a full FIFO is accepted only
// when a pop happens in the same cycle; otherwise it is dropped.
module ps2_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic                       rd_valid_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign pop_ok  = pop_i && !empty;
    assign push_ok = push_i && (!full_o || pop_ok);

    // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are masked at the output while empty, so no reset needed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign rd_data_o  = empty ? '0 : mem_q[rd_ptr_q];
    assign rd_valid_o = !empty;
    assign count_o    = count_q;
endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host frame receiver feeding a byte FIFO.
//
// state  | meaning
// IDLE   | bus idle, waiting for a start bit (falling edge with data 0)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the odd-parity bit
// STOP   | capturing the stop bit, then push or flag an error
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ps2_clk,
    input  logic            ps2_data,
    ps2_rx_fifo_if.master   rd_if,
    output logic            parity_err,
    output logic            frame_err,
    output logic            overflow
);
    localparam int             TO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam int             BIT_W    = $clog2(PS2_DATA_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PS2_DATA_BITS - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   clk_prev_q;
    logic                   clk_s;
    logic                   data_s;
    logic                   fall;

    ps2_state_e                 state_q, state_d;
    logic [BIT_W-1:0]           bit_cnt_q, bit_cnt_d;
    logic [PS2_DATA_BITS-1:0]   shift_q, shift_d;
    logic                       acc_q, acc_d;
    logic                       parity_ok_q, parity_ok_d;
    logic [TO_W-1:0]            timeout_q, timeout_d;
    logic                       push;
    logic                       parity_err_q, parity_err_d;
    logic                       frame_err_q, frame_err_d;
    logic                       overflow_q, overflow_d;
    logic                       pop;
    logic                       fifo_full;

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];
    assign fall   = clk_prev_q && !clk_s;

    // Synchronise both PS/2 lines; reset to 1 so an idle bus never looks like an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
            clk_prev_q  <= clk_s;
        end
    end

    // Frame FSM next-state: every non-idle state shares the timeout watchdog.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        acc_d        = acc_q;
        parity_ok_d  = parity_ok_q;
        timeout_d    = timeout_q;
        push         = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;

        if (state_q == ST_IDLE) begin
            timeout_d = '0;
            if (fall && !data_s) begin
                state_d   = ST_DATA;
                bit_cnt_d = '0;
                acc_d     = 1'b1;
            end
        end else if (fall) begin
            timeout_d = '0;
            case (state_q)
                ST_DATA: begin
                    shift_d   = {data_s, shift_q[PS2_DATA_BITS-1:1]};
                    acc_d     = acc_q ^ data_s;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    parity_ok_d = (acc_q == data_s);
                    state_d     = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (!data_s) begin
                        frame_err_d = 1'b1;
                    end else if (parity_ok_q) begin
                        push = 1'b1;
                    end else begin
                        parity_err_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (timeout_q == TO_LAST) begin
            state_d     = ST_IDLE;
            timeout_d   = '0;
            shift_d     = '0;
            frame_err_d = 1'b1;
        end else begin
            timeout_d = timeout_q + 1'b1;
        end
    end

    // Frame FSM state and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            acc_q       <= 1'b0;
            parity_ok_q <= 1'b0;
            timeout_q   <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            acc_q       <= acc_d;
            parity_ok_q <= parity_ok_d;
            timeout_q   <= timeout_d;
        end
    end

    assign pop        = rd_if.rd_valid && rd_if.rd_ready;
    assign overflow_d = push && fifo_full && !pop;

    // Status pulses are registered so each lasts exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overflow_q   <= overflow_d;
        end
    end

    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;

    ps2_sync_fifo #(
        .WIDTH (PS2_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (shift_q),
        .pop_i       (pop),
        .rd_data_o   (rd_if.rd_data),
        .rd_valid_o  (rd_if.rd_valid),
        .count_o     (rd_if.fifo_count),
        .full_o      (fifo_full)
    );
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed and randomised PS/2 frames against a queue-based reference model.
module tb_ps2_rx_fifo;
    localparam int DEPTH = 8;
    localparam int TO    = 200;
    localparam int H     = 20;   // clk cycles per PS/2 clock half-period

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    logic parity_err, frame_err, overflow;

    always #5 clk = ~clk;

    ps2_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) rd_if ();

    ps2_rx_fifo #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TO),
        .SYNC_STAGES    (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rd_if      (rd_if),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    int n_perr = 0, n_ferr = 0, n_ovf = 0;
    int exp_perr = 0, exp_ferr = 0, exp_ovf = 0;
    int total = 0, passed = 0, failed = 0;
    logic [7:0] model_q [$];

    always @(negedge clk) begin
        if (parity_err === 1'b1) n_perr++;
        if (frame_err === 1'b1)  n_ferr++;
        if (overflow === 1'b1)   n_ovf++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        logic [7:0] front;
        front = (model_q.size() != 0) ? model_q[0] : 8'h00;
        chk({tag, ".count"}, 32'(rd_if.fifo_count), 32'(model_q.size()));
        chk({tag, ".valid"}, 32'(rd_if.rd_valid), 32'(model_q.size() != 0));
        chk({tag, ".data"}, 32'(rd_if.rd_data), 32'(front));
        chk({tag, ".perr"}, 32'(n_perr), 32'(exp_perr));
        chk({tag, ".ferr"}, 32'(n_ferr), 32'(exp_ferr));
        chk({tag, ".ovf"}, 32'(n_ovf), 32'(exp_ovf));
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop);
        logic p;
        p = ~(^d) ^ bad_par;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(stop);
        ps2_data = 1'b1;
        repeat (H) @(negedge clk);
        if (!stop)                       exp_ferr++;
        else if (bad_par)                exp_perr++;
        else if (model_q.size() >= DEPTH) exp_ovf++;
        else                             model_q.push_back(d);
    endtask

    task automatic pop_one(input string tag);
        chk({tag, ".pop_valid"}, 32'(rd_if.rd_valid), 32'd1);
        chk({tag, ".pop_data"}, 32'(rd_if.rd_data), 32'(model_q[0]));
        rd_if.rd_ready = 1'b1;
        @(negedge clk);
        rd_if.rd_ready = 1'b0;
        void'(model_q.pop_front());
    endtask

    initial begin
        rd_if.rd_ready = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_state("reset");

        // good 0x1C
        send_frame(8'h1C, 1'b0, 1'b1);
        check_state("good_1c");
        pop_one("pop_1c");
        check_state("after_pop_1c");

        // bad parity, then good 0xF0
        send_frame(8'h1C, 1'b1, 1'b1);
        check_state("badpar_1c");
        send_frame(8'hF0, 1'b0, 1'b1);
        check_state("good_f0");
        pop_one("pop_f0");

        // timeout after start + 3 data bits
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        repeat (TO - H - 10) @(negedge clk);
        chk("timeout_early.ferr", 32'(n_ferr), 32'(exp_ferr));
        repeat (40) @(negedge clk);
        exp_ferr++;
        check_state("timeout");
        send_frame(8'h5A, 1'b0, 1'b1);
        check_state("good_5a");
        pop_one("pop_5a");

        // fill past depth, then drain
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1);
        check_state("overflow");
        for (int i = 0; i < DEPTH; i++) pop_one("drain");
        check_state("drained");

        // bad stop bit
        send_frame(8'h33, 1'b0, 1'b0);
        check_state("badstop_33");

        // reset mid-frame with two bytes queued
        send_frame(8'hA1, 1'b0, 1'b1);
        send_frame(8'hB2, 1'b0, 1'b1);
        check_state("pre_rst");
        for (int i = 0; i < 5; i++) send_bit(1'(i != 0 && (i % 2 == 1)));
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ps2_data = 1'b1;
        model_q.delete();
        repeat (5) @(negedge clk);
        check_state("mid_rst");
        send_frame(8'hC3, 1'b0, 1'b1);
        check_state("post_rst");

        // randomised frames with occasional errors and pops between frames
        for (int n = 0; n < 20; n++) begin
            logic [7:0] d;
            int k;
            int pops;
            d = 8'($urandom_range(0, 255));
            k = int'($urandom_range(0, 5));
            send_frame(d, 1'(k == 0), 1'(k != 1));
            check_state("rand");
            pops = int'($urandom_range(0, 2));
            for (int p = 0; p < pops; p++) begin
                if (model_q.size() != 0) pop_one("rand_pop");
            end
        end
        while (model_q.size() != 0) pop_one("final_drain");
        check_state("final");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
